uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver for the PMOD serial link; the far end of the host's transmitter.
- Deserialises 8N1 frames from the rx pin and buffers them in a small first-word-fall-through FIFO with a valid/ready read port toward the SoC bus.
- Drives the RTS flow-control pin so the host pauses before the FIFO overflows.

Parameters:
- FREQ_HZ, 16000000, system clock frequency in Hz.
- BAUDS, 115200, line rate; CLKS_PER_BIT = FREQ_HZ / BAUDS (integer division, truncated), must be >= 4.
- FIFO_DEPTH, 16, entries; power of two, >= 4.
- RTS_MARGIN, 4, free entries remaining at which rts_o drops; < FIFO_DEPTH/2.

Ports:
- clk, in, 1, system clock.
- reset_i, in, 1, synchronous active-high reset.
- rx_i, in, 1, asynchronous serial input, idle high.
- rts_o, out, 1, 1 = peer may send, 0 = peer must pause.
- data_o, out, 8, FIFO head byte; valid only while valid_o = 1.
- valid_o, out, 1, FIFO not empty.
- ready_i, in, 1, consumer accepts data_o this cycle.
- overrun_o, out, 1, sticky: a byte was dropped because the FIFO was full.
- frame_err_o, out, 1, sticky: stop bit sampled low.
- clear_i, in, 1, clears both sticky flags.

Behaviour:
- One clock domain. Reset is synchronous and active-high on reset_i, clocked by clk.
- Reset values:
  - rts_o = 0, valid_o = 0, data_o = 0, overrun_o = 0, frame_err_o = 0.
  - FIFO empty; FSM in IDLE.
  - Both synchroniser flops = 1.
- rts_o goes to 1 on the first cycle after reset deasserts.
- rx_i passes through a 2-flop synchroniser. All decisions use the synchronised value rxs.
- The bit-timer counts 0..CLKS_PER_BIT-1 and is reloaded on every state transition.
- FSM states:
  - IDLE: rxs = 0 -> START; timer loads for a half-bit (CLKS_PER_BIT/2 cycles).
  - START: at half-bit, rxs = 0 -> DATA with bit index 0. rxs = 1 -> IDLE, treated as a glitch with no flags set.
  - DATA: sample rxs every CLKS_PER_BIT cycles into the shift register, LSB first. After bit 7 -> STOP.
  - STOP: sample once, CLKS_PER_BIT after bit 7.
    - rxs = 1 -> push the byte, then IDLE.
    - rxs = 0 -> set frame_err_o, discard the byte, then BREAK.
  - BREAK: wait for rxs = 1, then IDLE. A held-low line (break) yields exactly one frame error, not repeated frames.
- Returning to IDLE at mid-stop-bit is intentional; it gives half a bit of resync margin.
- Push latency: the byte is on data_o with valid_o = 1 on the cycle after the stop-sample cycle, if the FIFO was empty.
- FIFO read:
  - First-word-fall-through; pop when valid_o && ready_i.
  - data_o is stable while valid_o = 1 and ready_i = 0.
- Push when full:
  - If a pop occurs the same cycle, the push is accepted and the count is unchanged.
  - Otherwise the byte is dropped and overrun_o is set.
- Push to empty with no pop: count goes 0 -> 1. Pointers wrap modulo FIFO_DEPTH.
- RTS hysteresis:
  - rts_o <= 0 when the next-cycle count >= FIFO_DEPTH - RTS_MARGIN.
  - rts_o <= 1 when the next-cycle count <= FIFO_DEPTH/2.
  - Otherwise rts_o holds. rts_o is registered.
- Sticky flags:
  - clear_i clears them.
  - If a set event and clear_i occur in the same cycle, set wins.
- Reset mid-frame: the FSM returns to IDLE and the partial byte and all FIFO contents are discarded. After reset, a line still low is seen as a start bit; this is accepted behaviour.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, BREAK).
  - Function clks_per_bit(freq, baud).
  - Frame constants DATA_BITS = 8 and STOP_BITS = 1.
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports: push/din, pop/dout, count, full, empty.
  - Reusable by the future TX path.
- Top file holds the synchroniser, FSM, bit timer, RTS logic and sticky flags.

Test Plan (FREQ_HZ = 16000000, BAUDS = 1000000 -> 16 clocks/bit, FIFO_DEPTH = 16, RTS_MARGIN = 4):
- Single byte: send 0xA5 8N1 with ready_i = 1 -> valid_o pulses one cycle with data_o = 0xA5 one cycle after the stop sample; flags stay 0.
- Burst and backpressure: with ready_i = 0, send 0x00..0x0B -> rts_o falls after the 12th byte. Raise ready_i and drain to 8 entries -> rts_o returns to 1. Read order is 0x00..0x0B.
- Overrun: with ready_i = 0, send 17 bytes -> 16 buffered; overrun_o = 1; byte 17 is absent on drain. Pulse clear_i -> overrun_o = 0.
- Framing and break: send 0x3C with stop bit = 0 -> frame_err_o = 1, no push. Hold rx low for 40 bit-times -> still exactly one error and no push. Release and send 0x55 -> 0x55 received.
- Glitch: rx_i low for 5 cycles only -> no start, FSM back to IDLE, no push, no flags.
- Reset mid-frame: assert reset_i during data bit 3 of 0xFF with 2 bytes buffered -> valid_o = 0 and rts_o = 0 in reset. After reset, a fresh 0x81 arrives alone.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path (and the future transmit path).
//   rx_state_t   : receiver FSM states
//   clks_per_bit : integer clocks per serial bit for a given clock and line rate
//   DATA_BITS / STOP_BITS : 8N1 frame shape
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Wide enough to index every data and stop bit of a frame.
    localparam int BIT_IDX_W = $clog2(DATA_BITS + STOP_BITS);

    // Truncating division: the bit timer runs slightly fast rather than slow.
    function automatic int clks_per_bit(input int freq_hz, input int baud);
        return freq_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   push_i/din_i  : write request and data; ignored when full unless a pop
//                   happens in the same cycle (then the write replaces the
//                   slot being freed).
//   pop_i/dout_o  : read request and head word; dout_o is zero while empty.
//   count_o       : current occupancy, 0..DEPTH.
//   full_o/empty_o: occupancy flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Asynchronous read so a word written into an empty FIFO is visible on
    // the very next cycle.
    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a FWFT receive FIFO and RTS flow control.
//   clk, reset_i : system clock, synchronous active-high reset
//   rx_i         : serial input (idle high), synchronised internally
//   rts_o        : 1 = peer may send, 0 = peer must pause
//   data_o       : FIFO head byte, valid while valid_o = 1
//   valid_o      : FIFO not empty
//   ready_i      : consumer takes data_o this cycle
//   overrun_o    : sticky, a received byte was dropped (FIFO full)
//   frame_err_o  : sticky, stop bit sampled low
//   clear_i      : clears both sticky flags (a simultaneous set wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FREQ_HZ    = 16000000,
    parameter int BAUDS      = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic       rts_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       overrun_o,
    output logic       frame_err_o,
    input  logic       clear_i
);

    localparam int CPB = clks_per_bit(FREQ_HZ, BAUDS);
    localparam int TW  = $clog2(CPB);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [TW-1:0] BIT_LAST    = TW'(CPB - 1);
    localparam logic [TW-1:0] HALF_LAST   = TW'(CPB / 2 - 1);
    localparam logic [CW-1:0] RTS_LOW_AT  = CW'(FIFO_DEPTH - RTS_MARGIN);
    localparam logic [CW-1:0] RTS_HIGH_AT = CW'(FIFO_DEPTH / 2);
    localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_BITS - 1);

    // ---------------------------------------------------------------
    // Two-flop synchroniser, reset to the idle (high) line level.
    // ---------------------------------------------------------------
    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       rxs;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = rx_i;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rxs = sync_q[1];

    // ---------------------------------------------------------------
    // Receiver FSM with bit timer. The timer restarts at zero on every
    // state change, so START waits a half bit and DATA/STOP a full bit,
    // which lands every sample near the middle of its bit.
    // ---------------------------------------------------------------
    rx_state_t              state_q;
    logic [TW-1:0]          timer_q;
    logic [BIT_IDX_W-1:0]   bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   tick_half;
    logic                   tick_bit;

    assign tick_half = (timer_q == HALF_LAST);
    assign tick_bit  = (timer_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (!rxs) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick_half) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        // A line already back high at mid start bit was noise.
                        state_q   <= rxs ? IDLE : DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_bit) begin
                        timer_q <= '0;
                        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_DATA_IDX) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_bit) begin
                        timer_q <= '0;
                        // Leaving at mid stop bit leaves half a bit to
                        // resynchronise on the next start edge.
                        state_q <= rxs ? IDLE : BREAK;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                BREAK: begin
                    // Hold here while the line stays low so a break
                    // reports one frame error, not a stream of zero bytes.
                    timer_q <= '0;
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    logic stop_sample;
    logic push_req;
    logic frame_set;

    assign stop_sample = (state_q == STOP) && tick_bit;
    assign push_req    = stop_sample && rxs;
    assign frame_set   = stop_sample && !rxs;

    // ---------------------------------------------------------------
    // Receive FIFO
    // ---------------------------------------------------------------
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_eff;
    logic          push_acc;
    logic [CW-1:0] count_next;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_i (reset_i),
        .push_i  (push_req),
        .din_i   (shift_q),
        .pop_i   (ready_i),
        .dout_o  (data_o),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign valid_o  = !fifo_empty;
    assign pop_eff  = ready_i && !fifo_empty;
    assign push_acc = push_req && (!fifo_full || pop_eff);

    // Occupancy after this cycle's push/pop; RTS reacts to it in the same
    // edge as the FIFO update.
    assign count_next = fifo_count + CW'(push_acc) - CW'(pop_eff);

    // ---------------------------------------------------------------
    // RTS hysteresis and sticky error flags
    // ---------------------------------------------------------------
    logic rts_q, rts_d;
    logic overrun_q, overrun_d;
    logic frame_err_q, frame_err_d;
    logic overrun_set;

    assign overrun_set = push_req && fifo_full && !pop_eff;

    always_comb begin
        rts_d = rts_q;
        if (count_next >= RTS_LOW_AT) begin
            rts_d = 1'b0;
        end else if (count_next <= RTS_HIGH_AT) begin
            rts_d = 1'b1;
        end
    end

    assign overrun_d   = overrun_set | (overrun_q & ~clear_i);
    assign frame_err_d = frame_set   | (frame_err_q & ~clear_i);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            rts_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rts_q       <= rts_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rts_o       = rts_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at 16 clocks per bit, 16-entry FIFO.
module tb_uart_rx_fifo;

    localparam int FREQ   = 16000000;
    localparam int BAUD   = 1000000;
    localparam int CPB    = FREQ / BAUD;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       rx_i;
    logic       rts_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       overrun_o;
    logic       frame_err_o;
    logic       clear_i;

    int tests_run = 0;
    int fails     = 0;

    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .FREQ_HZ    (FREQ),
        .BAUDS      (BAUD),
        .FIFO_DEPTH (DEPTH),
        .RTS_MARGIN (MARGIN)
    ) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .rx_i        (rx_i),
        .rts_o       (rts_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o),
        .clear_i     (clear_i)
    );

    // Every accepted read handshake, in order.
    always @(negedge clk) begin
        if (valid_o && ready_i && !reset_i) got_q.push_back(data_o);
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        rx_i = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            cycles(CPB);
        end
        rx_i = stop_lvl;
        cycles(CPB);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        cycles(3);
        tests_run++; if (rts_o !== 1'b0) begin fails++; $display("FAIL reset_rts: got %b expected 0", rts_o); end
        tests_run++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        tests_run++; if (data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data_o); end
        tests_run++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
        tests_run++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err_o); end
        reset_i = 1'b0;
        cycles(1);
        tests_run++; if (rts_o !== 1'b1) begin fails++; $display("FAIL rts_after_reset: got %b expected 1", rts_o); end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        logic [7:0] b = 8'hA5;
        int first_k = -1;
        int vcount = 0;
        logic [7:0] head = 8'h00;
        ready_i = 1'b1;
        got_q.delete();
        rx_i = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            cycles(CPB);
        end
        tests_run++; if (got_q.size() != 0) begin fails++; $display("FAIL single_early: got %0d reads expected 0 before stop bit", got_q.size()); end
        rx_i = 1'b1;
        for (int k = 1; k <= CPB + 4; k++) begin
            cycles(1);
            if (valid_o) begin
                vcount++;
                if (first_k < 0) begin first_k = k; head = data_o; end
            end
        end
        tests_run++; if (first_k < CPB / 2 || first_k > CPB) begin fails++; $display("FAIL single_latency: valid first seen %0d cycles into stop bit, expected %0d..%0d", first_k, CPB / 2, CPB); end
        tests_run++; if (head !== b) begin fails++; $display("FAIL single_data: got %h expected %h", head, b); end
        tests_run++; if (vcount != 1) begin fails++; $display("FAIL single_pulse: valid high %0d cycles expected 1", vcount); end
        tests_run++; if (got_q.size() != 1) begin fails++; $display("FAIL single_reads: got %0d expected 1", got_q.size()); end
        tests_run++; if ({overrun_o, frame_err_o} !== 2'b00) begin fails++; $display("FAIL single_flags: got %b expected 00", {overrun_o, frame_err_o}); end
        $display("[TB] single byte %h: first valid at stop+%0d, %0d valid cycles", b, first_k, vcount);
    endtask

    task automatic test_burst();
        logic [7:0] exp_q[$];
        int cnt = 0;
        logic model_rts = 1'b1;
        ready_i = 1'b0;
        got_q.delete();
        for (int n = 0; n < 12; n++) begin
            send_frame(8'(n), 1'b1);
            exp_q.push_back(8'(n));
            cnt++;
            if (cnt >= DEPTH - MARGIN) model_rts = 1'b0;
            tests_run++; if (rts_o !== model_rts) begin fails++; $display("FAIL burst_rts_fill: after byte %0d got %b expected %b", n + 1, rts_o, model_rts); end
            $display("[TB] burst byte %h sent, count %0d, rts %b", 8'(n), cnt, rts_o);
        end
        for (int p = 0; p < 4; p++) begin
            ready_i = 1'b1;
            cycles(1);
            ready_i = 1'b0;
            cycles(1);
            cnt--;
            if (cnt <= DEPTH / 2) model_rts = 1'b1;
            tests_run++; if (rts_o !== model_rts) begin fails++; $display("FAIL burst_rts_drain: at count %0d got %b expected %b", cnt, rts_o, model_rts); end
            $display("[TB] burst pop, count %0d, rts %b", cnt, rts_o);
        end
        ready_i = 1'b1;
        cycles(24);
        tests_run++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL burst_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL burst_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        tests_run++; if (valid_o !== 1'b0) begin fails++; $display("FAIL burst_empty: valid got %b expected 0", valid_o); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        ready_i = 1'b0;
        got_q.delete();
        for (int n = 0; n < DEPTH + 1; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            if (n == DEPTH - 1) begin
                tests_run++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL overrun_early: got %b expected 0", overrun_o); end
            end
            $display("[TB] overrun byte %0d = %h, overrun %b", n + 1, b, overrun_o);
        end
        tests_run++; if (overrun_o !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b expected 1", overrun_o); end
        tests_run++; if (rts_o !== 1'b0) begin fails++; $display("FAIL overrun_rts: got %b expected 0", rts_o); end
        ready_i = 1'b1;
        cycles(DEPTH + 8);
        tests_run++; if (got_q.size() != DEPTH) begin fails++; $display("FAIL overrun_count: got %0d expected %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL overrun_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        tests_run++; if (overrun_o !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b expected 1", overrun_o); end
        clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0;
        cycles(1);
        tests_run++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %b expected 0", overrun_o); end
    endtask

    task automatic test_frame_break();
        ready_i = 1'b1;
        got_q.delete();
        send_frame(8'h3C, 1'b0);
        $display("[TB] frame 3C with low stop bit, frame_err %b", frame_err_o);
        tests_run++; if (frame_err_o !== 1'b1) begin fails++; $display("FAIL frame_err_set: got %b expected 1", frame_err_o); end
        tests_run++; if (got_q.size() != 0) begin fails++; $display("FAIL frame_no_push: got %0d reads expected 0", got_q.size()); end
        clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0;
        tests_run++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL frame_clear: got %b expected 0", frame_err_o); end
        cycles(40 * CPB);
        $display("[TB] break held 40 bits, frame_err %b, reads %0d", frame_err_o, got_q.size());
        tests_run++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL break_single_err: got %b expected 0", frame_err_o); end
        tests_run++; if (got_q.size() != 0 || valid_o !== 1'b0) begin fails++; $display("FAIL break_no_push: got %0d reads valid %b expected 0 reads", got_q.size(), valid_o); end
        rx_i = 1'b1;
        cycles(2 * CPB);
        send_frame(8'h55, 1'b1);
        cycles(4);
        tests_run++; if (got_q.size() != 1) begin fails++; $display("FAIL break_recover_count: got %0d expected 1", got_q.size()); end
        else begin
            tests_run++; if (got_q[0] !== 8'h55) begin fails++; $display("FAIL break_recover_data: got %h expected 55", got_q[0]); end
        end
        tests_run++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL break_recover_flag: got %b expected 0", frame_err_o); end
    endtask

    task automatic test_glitch();
        ready_i = 1'b1;
        got_q.delete();
        rx_i = 1'b0;
        cycles(5);
        rx_i = 1'b1;
        cycles(2 * CPB);
        $display("[TB] glitch 5 cycles, reads %0d flags %b%b", got_q.size(), overrun_o, frame_err_o);
        tests_run++; if (got_q.size() != 0 || valid_o !== 1'b0) begin fails++; $display("FAIL glitch_no_push: got %0d reads expected 0", got_q.size()); end
        tests_run++; if ({overrun_o, frame_err_o} !== 2'b00) begin fails++; $display("FAIL glitch_flags: got %b expected 00", {overrun_o, frame_err_o}); end
        send_frame(8'h5A, 1'b1);
        cycles(4);
        tests_run++; if (got_q.size() != 1) begin fails++; $display("FAIL glitch_next_count: got %0d expected 1", got_q.size()); end
        else begin
            tests_run++; if (got_q[0] !== 8'h5A) begin fails++; $display("FAIL glitch_next_data: got %h expected 5a", got_q[0]); end
        end
    endtask

    task automatic test_reset_midframe();
        ready_i = 1'b0;
        got_q.delete();
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        tests_run++; if (valid_o !== 1'b1) begin fails++; $display("FAIL midreset_buffered: valid got %b expected 1", valid_o); end
        rx_i = 1'b0;
        cycles(CPB);
        rx_i = 1'b1;
        cycles(3 * CPB + CPB / 2);
        reset_i = 1'b1;
        cycles(2);
        $display("[TB] reset during data bit 3: valid %b rts %b", valid_o, rts_o);
        tests_run++; if (valid_o !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b expected 0", valid_o); end
        tests_run++; if (rts_o !== 1'b0) begin fails++; $display("FAIL midreset_rts: got %b expected 0", rts_o); end
        cycles(2);
        reset_i = 1'b0;
        cycles(6 * CPB);
        tests_run++; if (valid_o !== 1'b0 || got_q.size() != 0) begin fails++; $display("FAIL midreset_discard: valid %b reads %0d expected 0/0", valid_o, got_q.size()); end
        tests_run++; if (rts_o !== 1'b1) begin fails++; $display("FAIL midreset_rts_back: got %b expected 1", rts_o); end
        ready_i = 1'b1;
        send_frame(8'h81, 1'b1);
        cycles(4);
        tests_run++; if (got_q.size() != 1) begin fails++; $display("FAIL midreset_fresh_count: got %0d expected 1", got_q.size()); end
        else begin
            tests_run++; if (got_q[0] !== 8'h81) begin fails++; $display("FAIL midreset_fresh_data: got %h expected 81", got_q[0]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        bit done = 1'b0;
        got_q.delete();
        for (int n = 0; n < 10; n++) exp_q.push_back(8'($urandom_range(0, 255)));
        fork
            begin
                for (int n = 0; n < 10; n++) begin
                    b = exp_q[n];
                    send_frame(b, 1'b1);
                    $display("[TB] random byte %0d = %h sent", n, b);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    cycles(1);
                    ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        ready_i = 1'b1;
        cycles(20);
        tests_run++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL random_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        tests_run++; if ({overrun_o, frame_err_o} !== 2'b00) begin fails++; $display("FAIL random_flags: got %b expected 00", {overrun_o, frame_err_o}); end
    endtask

    initial begin
        rx_i    = 1'b1;
        ready_i = 1'b0;
        clear_i = 1'b0;
        reset_i = 1'b1;
        test_reset();
        cycles(CPB);
        test_single();
        cycles(CPB);
        test_burst();
        cycles(CPB);
        test_overrun();
        cycles(CPB);
        test_frame_break();
        cycles(CPB);
        test_glitch();
        cycles(CPB);
        test_reset_midframe();
        cycles(CPB);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
